jt12_wr_dec: RTL and testbench

- CPU-side register write decoder for the FM core; sits directly upstream of the operator/channel register file.
- Captures YM2612-style bus writes: address/data ports on two parts.
- Decodes each data write into one held update strobe plus din/ch/op, and handshakes on the register file's busy.
- Holds global registers directly: timers, CH3 mode/CSM, LFO, CH3 special fnums, optional PCM.

---
 rtl/jt12_wr_pkg.sv | 72 +++++++
 rtl/jt12_ch3_fnum.sv | 48 ++++
 rtl/jt12_wr_dec.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_jt12_wr_dec.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt12_wr_pkg.sv
// Shared constants, FSM state and strobe indices for the jt12 CPU write decoder.
package jt12_wr_pkg;

    // Per-channel/per-operator register groups, selected by reg[7:4]
    localparam logic [3:0] REG_DT1      = 4'h3;
    localparam logic [3:0] REG_TL       = 4'h4;
    localparam logic [3:0] REG_KS_AR    = 4'h5;
    localparam logic [3:0] REG_AMEN_D1R = 4'h6;
    localparam logic [3:0] REG_D2R      = 4'h7;
    localparam logic [3:0] REG_D1L      = 4'h8;
    localparam logic [3:0] REG_SSGEG    = 4'h9;
    localparam logic [3:0] REG_FREQ     = 4'hA;
    localparam logic [3:0] REG_ALG      = 4'hB;

    localparam logic [7:0] REG_LFO      = 8'h22;
    localparam logic [7:0] REG_TA_HI    = 8'h24;
    localparam logic [7:0] REG_TA_LO    = 8'h25;
    localparam logic [7:0] REG_TB       = 8'h26;
    localparam logic [7:0] REG_MODE     = 8'h27;
    localparam logic [7:0] REG_KEYON    = 8'h28;
    localparam logic [7:0] REG_PCM_DATA = 8'h2A;
    localparam logic [7:0] REG_PCM_EN   = 8'h2B;
    localparam logic [7:0] REG_PCM_LSB  = 8'h2C;
    localparam logic [7:0] REG_CH3_OP3  = 8'hA8;
    localparam logic [7:0] REG_CH3_OP1  = 8'hA9;
    localparam logic [7:0] REG_CH3_OP2  = 8'hAA;
    localparam logic [7:0] REG_CH3_HI_LO = 8'hAC;
    localparam logic [7:0] REG_CH3_HI_HI = 8'hAE;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACK  = 2'd1,
        S_WAIT_DONE = 2'd2
    } wr_state_e;

    typedef enum logic [3:0] {
        UP_KEYON    = 4'd0,
        UP_DT1      = 4'd1,
        UP_TL       = 4'd2,
        UP_KS_AR    = 4'd3,
        UP_AMEN_D1R = 4'd4,
        UP_D2R      = 4'd5,
        UP_D1L      = 4'd6,
        UP_SSGEG    = 4'd7,
        UP_FNUMLO   = 4'd8,
        UP_BLOCK    = 4'd9,
        UP_ALG      = 4'd10,
        UP_PMS      = 4'd11
    } up_idx_e;

    localparam int NUM_UP = 12;

    typedef struct packed {
        logic       lfo_en;
        logic [2:0] lfo_freq;
        logic [9:0] value_A;
        logic [7:0] value_B;
        logic       effect;
        logic       csm;
        logic       load_A;
        logic       load_B;
        logic       en_irq_A;
        logic       en_irq_B;
        logic       clr_flag_A;
        logic       clr_flag_B;
    } glb_t;

    function automatic logic is_ch3_hi(input logic [7:0] a);
        return (a >= REG_CH3_HI_LO) && (a <= REG_CH3_HI_HI);
    endfunction

endpackage

// File: rtl/jt12_ch3_fnum.sv
// CH3 special-mode fnum/block registers: a hi write only loads the shared
// shadow, the following lo write commits {shadow, din} to one operator.
module jt12_ch3_fnum
    import jt12_wr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hi_we_i,
    input  logic [2:0]  lo_we_i,   // [0]=op1, [1]=op2, [2]=op3
    input  logic [7:0]  din_i,
    output logic [10:0] fnum_op1_o,
    output logic [10:0] fnum_op2_o,
    output logic [10:0] fnum_op3_o,
    output logic [2:0]  block_op1_o,
    output logic [2:0]  block_op2_o,
    output logic [2:0]  block_op3_o
);

    logic [5:0]        shadow_q;
    logic [2:0][10:0]  fnum_q;
    logic [2:0][2:0]   block_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= '0;
            fnum_q   <= '0;
            block_q  <= '0;
        end else begin
            if (hi_we_i) begin
                shadow_q <= din_i[5:0];
            end
            for (int i = 0; i < 3; i++) begin
                if (lo_we_i[i]) begin
                    block_q[i] <= shadow_q[5:3];
                    fnum_q[i]  <= {shadow_q[2:0], din_i};
                end
            end
        end
    end

    assign fnum_op1_o  = fnum_q[0];
    assign fnum_op2_o  = fnum_q[1];
    assign fnum_op3_o  = fnum_q[2];
    assign block_op1_o = block_q[0];
    assign block_op2_o = block_q[1];
    assign block_op3_o = block_q[2];

endmodule

// File: rtl/jt12_wr_dec.sv
// YM2612-style CPU write decoder: global registers plus a held-strobe handshake
// towards the register file. Define JT12_PCM_EN to add the PCM registers.
module jt12_wr_dec
    import jt12_wr_pkg::*;
#(
    parameter int ACK_TIMEOUT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cpu_din,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_cs_n,
    input  logic        cpu_wr_n,
    input  logic        busy_in,
    output logic        busy,
    output logic [7:0]  din,
    output logic [2:0]  ch,
    output logic [1:0]  op,
    output logic        up_keyon,
    output logic        up_dt1,
    output logic        up_tl,
    output logic        up_ks_ar,
    output logic        up_amen_d1r,
    output logic        up_d2r,
    output logic        up_d1l,
    output logic        up_ssgeg,
    output logic        up_fnumlo,
    output logic        up_block,
    output logic        up_alg,
    output logic        up_pms,
    output logic        effect,
    output logic        csm,
    output logic        lfo_en,
    output logic [2:0]  lfo_freq,
    output logic [9:0]  value_A,
    output logic [7:0]  value_B,
    output logic        load_A,
    output logic        load_B,
    output logic        en_irq_A,
    output logic        en_irq_B,
    output logic        clr_flag_A,
    output logic        clr_flag_B,
    output logic [10:0] fnum_ch3op1,
    output logic [10:0] fnum_ch3op2,
    output logic [10:0] fnum_ch3op3,
    output logic [2:0]  block_ch3op1,
    output logic [2:0]  block_ch3op2,
    output logic [2:0]  block_ch3op3,
`ifdef JT12_PCM_EN
    output logic [8:0]  pcm,
    output logic        pcm_en,
    output logic        pcm_wr,
`endif
    output logic [1:0]  dbg_state_o
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    // Handshake: a strobe in sel_q is held from entry into WAIT_ACK until the
    // register file releases busy_in (or never raises it within ACK_TIMEOUT
    // cycles); busy mirrors "strobe pending" and CPU data writes are dropped
    // while it is high. Returning to IDLE always gives a strobe-low cycle.
    wr_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_UP-1:0]  sel_q, sel_d;
    logic [7:0]         din_q, din_d;
    logic [2:0]         ch_q, ch_d;
    logic [1:0]         op_q, op_d;
    logic               wr_n_q;
    logic [7:0]         addr_q;
    logic               part_q;
    glb_t               glb_q;

    logic        wr_ev, addr_wr, data_wr, glb_we;
    logic        grp_hit, is_keyon;
    up_idx_e     grp_idx;

    assign busy    = (state_q != S_IDLE);
    assign wr_ev   = !cpu_cs_n && !cpu_wr_n && wr_n_q;
    assign addr_wr = wr_ev && !cpu_addr[0];
    assign data_wr = wr_ev && cpu_addr[0] && !busy;
    assign glb_we  = data_wr && !part_q;
    assign is_keyon = (addr_q == REG_KEYON) && !part_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_n_q <= 1'b1;
            addr_q <= '0;
            part_q <= 1'b0;
        end else begin
            wr_n_q <= cpu_wr_n;
            if (addr_wr) begin
                addr_q <= cpu_din;
                part_q <= cpu_addr[1];
            end
        end
    end

    always_comb begin
        grp_hit = 1'b0;
        grp_idx = UP_KEYON;
        if (addr_q[1:0] != 2'd3) begin
            case (addr_q[7:4])
                REG_DT1:      begin grp_hit = 1'b1; grp_idx = UP_DT1;      end
                REG_TL:       begin grp_hit = 1'b1; grp_idx = UP_TL;       end
                REG_KS_AR:    begin grp_hit = 1'b1; grp_idx = UP_KS_AR;    end
                REG_AMEN_D1R: begin grp_hit = 1'b1; grp_idx = UP_AMEN_D1R; end
                REG_D2R:      begin grp_hit = 1'b1; grp_idx = UP_D2R;      end
                REG_D1L:      begin grp_hit = 1'b1; grp_idx = UP_D1L;      end
                REG_SSGEG:    begin grp_hit = 1'b1; grp_idx = UP_SSGEG;    end
                REG_FREQ: begin
                    grp_hit = !addr_q[3];
                    grp_idx = addr_q[2] ? UP_BLOCK : UP_FNUMLO;
                end
                REG_ALG: begin
                    grp_hit = !addr_q[3];
                    grp_idx = addr_q[2] ? UP_PMS : UP_ALG;
                end
                default: ;
            endcase
        end
        if (is_keyon) begin
            grp_hit = 1'b1;
            grp_idx = UP_KEYON;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            din_q   <= '0;
            ch_q    <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            din_q   <= din_d;
            ch_q    <= ch_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        din_d   = din_q;
        ch_d    = ch_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (data_wr && grp_hit) begin
                    state_d = S_WAIT_ACK;
                    cnt_d   = '0;
                    sel_d   = NUM_UP'(1) << grp_idx;
                    din_d   = cpu_din;
                    ch_d    = is_keyon ? cpu_din[2:0] : {part_q, addr_q[1:0]};
                    op_d    = is_keyon ? 2'd0 : addr_q[3:2];
                end
            end
            S_WAIT_ACK: begin
                if (busy_in) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_in) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // Part-0 globals take effect on the write itself; the flag clears are pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            glb_q <= '0;
        end else begin
            glb_q.clr_flag_A <= 1'b0;
            glb_q.clr_flag_B <= 1'b0;
            if (glb_we) begin
                case (addr_q)
                    REG_LFO: begin
                        glb_q.lfo_en   <= cpu_din[3];
                        glb_q.lfo_freq <= cpu_din[2:0];
                    end
                    REG_TA_HI: glb_q.value_A[9:2] <= cpu_din;
                    REG_TA_LO: glb_q.value_A[1:0] <= cpu_din[1:0];
                    REG_TB:    glb_q.value_B      <= cpu_din;
                    REG_MODE: begin
                        glb_q.effect     <= cpu_din[6];
                        glb_q.csm        <= (cpu_din[7:6] == 2'b10);
                        glb_q.load_A     <= cpu_din[0];
                        glb_q.load_B     <= cpu_din[1];
                        glb_q.en_irq_A   <= cpu_din[2];
                        glb_q.en_irq_B   <= cpu_din[3];
                        glb_q.clr_flag_A <= cpu_din[4];
                        glb_q.clr_flag_B <= cpu_din[5];
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef JT12_PCM_EN
    logic [8:0] pcm_q;
    logic       pcm_en_q;
    logic       pcm_wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_q    <= '0;
            pcm_en_q <= 1'b0;
            pcm_wr_q <= 1'b0;
        end else begin
            pcm_wr_q <= 1'b0;
            if (glb_we) begin
                case (addr_q)
                    REG_PCM_DATA: begin
                        pcm_q[8:1] <= cpu_din;
                        pcm_wr_q   <= 1'b1;
                    end
                    REG_PCM_EN:  pcm_en_q <= cpu_din[7];
                    REG_PCM_LSB: pcm_q[0] <= cpu_din[3];
                    default: ;
                endcase
            end
        end
    end

    assign pcm    = pcm_q;
    assign pcm_en = pcm_en_q;
    assign pcm_wr = pcm_wr_q;
`endif

    jt12_ch3_fnum u_ch3_fnum (
        .clk_i       (clk),
        .rst_i       (rst),
        .hi_we_i     (glb_we && is_ch3_hi(addr_q)),
        .lo_we_i     ({glb_we && (addr_q == REG_CH3_OP3),
                       glb_we && (addr_q == REG_CH3_OP2),
                       glb_we && (addr_q == REG_CH3_OP1)}),
        .din_i       (cpu_din),
        .fnum_op1_o  (fnum_ch3op1),
        .fnum_op2_o  (fnum_ch3op2),
        .fnum_op3_o  (fnum_ch3op3),
        .block_op1_o (block_ch3op1),
        .block_op2_o (block_ch3op2),
        .block_op3_o (block_ch3op3)
    );

    assign din         = din_q;
    assign ch          = ch_q;
    assign op          = op_q;
    assign up_keyon    = sel_q[UP_KEYON];
    assign up_dt1      = sel_q[UP_DT1];
    assign up_tl       = sel_q[UP_TL];
    assign up_ks_ar    = sel_q[UP_KS_AR];
    assign up_amen_d1r = sel_q[UP_AMEN_D1R];
    assign up_d2r      = sel_q[UP_D2R];
    assign up_d1l      = sel_q[UP_D1L];
    assign up_ssgeg    = sel_q[UP_SSGEG];
    assign up_fnumlo   = sel_q[UP_FNUMLO];
    assign up_block    = sel_q[UP_BLOCK];
    assign up_alg      = sel_q[UP_ALG];
    assign up_pms      = sel_q[UP_PMS];
    assign effect      = glb_q.effect;
    assign csm         = glb_q.csm;
    assign lfo_en      = glb_q.lfo_en;
    assign lfo_freq    = glb_q.lfo_freq;
    assign value_A     = glb_q.value_A;
    assign value_B     = glb_q.value_B;
    assign load_A      = glb_q.load_A;
    assign load_B      = glb_q.load_B;
    assign en_irq_A    = glb_q.en_irq_A;
    assign en_irq_B    = glb_q.en_irq_B;
    assign clr_flag_A  = glb_q.clr_flag_A;
    assign clr_flag_B  = glb_q.clr_flag_B;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_jt12_wr_dec.sv
// Directed bench for jt12_wr_dec: bus writes, strobe handshake, globals, CH3 fnums.
module tb_jt12_wr_dec;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  cpu_din = '0;
  logic [1:0]  cpu_addr = '0;
  logic        cpu_cs_n = 1'b1;
  logic        cpu_wr_n = 1'b1;
  logic        busy_in = 1'b0;
  logic        busy;
  logic [7:0]  din;
  logic [2:0]  ch;
  logic [1:0]  op;
  logic        up_keyon, up_dt1, up_tl, up_ks_ar, up_amen_d1r, up_d2r;
  logic        up_d1l, up_ssgeg, up_fnumlo, up_block, up_alg, up_pms;
  logic        effect, csm, lfo_en;
  logic [2:0]  lfo_freq;
  logic [9:0]  value_A;
  logic [7:0]  value_B;
  logic        load_A, load_B, en_irq_A, en_irq_B, clr_flag_A, clr_flag_B;
  logic [10:0] fnum_ch3op1, fnum_ch3op2, fnum_ch3op3;
  logic [2:0]  block_ch3op1, block_ch3op2, block_ch3op3;
  logic [1:0]  dbg_state;
`ifdef JT12_PCM_EN
  logic [8:0]  pcm;
  logic        pcm_en, pcm_wr;
`endif

  int n_checks = 0;
  int n_fail = 0;

  // bit i follows the strobe index order: keyon, dt1, tl, ... pms
  logic [11:0] ups;
  assign ups = {up_pms, up_alg, up_block, up_fnumlo, up_ssgeg, up_d1l,
                up_d2r, up_amen_d1r, up_ks_ar, up_tl, up_dt1, up_keyon};

  jt12_wr_dec dut (
    .clk(clk), .rst(rst), .cpu_din(cpu_din), .cpu_addr(cpu_addr),
    .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .busy_in(busy_in), .busy(busy),
    .din(din), .ch(ch), .op(op),
    .up_keyon(up_keyon), .up_dt1(up_dt1), .up_tl(up_tl), .up_ks_ar(up_ks_ar),
    .up_amen_d1r(up_amen_d1r), .up_d2r(up_d2r), .up_d1l(up_d1l),
    .up_ssgeg(up_ssgeg), .up_fnumlo(up_fnumlo), .up_block(up_block),
    .up_alg(up_alg), .up_pms(up_pms),
    .effect(effect), .csm(csm), .lfo_en(lfo_en), .lfo_freq(lfo_freq),
    .value_A(value_A), .value_B(value_B), .load_A(load_A), .load_B(load_B),
    .en_irq_A(en_irq_A), .en_irq_B(en_irq_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B),
    .fnum_ch3op1(fnum_ch3op1), .fnum_ch3op2(fnum_ch3op2), .fnum_ch3op3(fnum_ch3op3),
    .block_ch3op1(block_ch3op1), .block_ch3op2(block_ch3op2), .block_ch3op3(block_ch3op3),
`ifdef JT12_PCM_EN
    .pcm(pcm), .pcm_en(pcm_en), .pcm_wr(pcm_wr),
`endif
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got hang, required finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: one write strobe, wr_n low for exactly one sampled edge
  task automatic bus_write(input logic part, input logic is_data, input logic [7:0] d);
    @(negedge clk);
    cpu_cs_n = 1'b0;
    cpu_wr_n = 1'b0;
    cpu_addr = {part, is_data};
    cpu_din  = d;
    @(negedge clk);
    cpu_cs_n = 1'b1;
    cpu_wr_n = 1'b1;
  endtask

  task automatic reg_write(input logic part, input logic [7:0] a, input logic [7:0] d);
    bus_write(part, 1'b0, a);
    bus_write(part, 1'b1, d);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ups !== 12'h000) begin n_fail++; $display("FAIL reset_strobes: got %h required 000", ups); end
    n_checks++;
    if (busy !== 1'b0 || din !== 8'h00 || ch !== 3'd0 || op !== 2'd0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b din=%h ch=%0d op=%0d required all 0", busy, din, ch, op);
    end
    n_checks++;
    if (value_A !== 10'h0 || csm !== 1'b0 || fnum_ch3op1 !== 11'h0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_globals: value_A=%h csm=%b fnum1=%h state=%0d required 0", value_A, csm, fnum_ch3op1, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tl_handshake;
    reg_write(1'b0, 8'h40, 8'h7F);
    n_checks++;
    if (ups !== 12'h004 || busy !== 1'b1 || ch !== 3'd0 || op !== 2'd0 || din !== 8'h7F) begin
      n_fail++; $display("FAIL tl_launch: ups=%h busy=%b ch=%0d op=%0d din=%h required 004 1 0 0 7f", ups, busy, ch, op, din);
    end
    @(negedge clk);
    busy_in = 1'b1;
    repeat (22) @(negedge clk);
    n_checks++;
    if (ups !== 12'h004 || busy !== 1'b1 || dbg_state !== 2'd2) begin
      n_fail++; $display("FAIL tl_hold: ups=%h busy=%b state=%0d required 004 1 2", ups, busy, dbg_state);
    end
    busy_in = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ups !== 12'h000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL tl_release: ups=%h busy=%b required 000 0", ups, busy);
    end
  endtask

  task automatic test_dt1_drop;
    int n;
    reg_write(1'b1, 8'h3D, 8'h21);
    n_checks++;
    if (ups !== 12'h002 || ch !== 3'd5 || op !== 2'd3 || din !== 8'h21) begin
      n_fail++; $display("FAIL dt1_launch: ups=%h ch=%0d op=%0d din=%h required 002 5 3 21", ups, ch, op, din);
    end
    bus_write(1'b1, 1'b1, 8'h55);
    n = 0;
    while (busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL dt1_timeout: busy=%b after %0d cycles required 0", busy, n); end
    repeat (4) @(negedge clk);
    n_checks++;
    if (ups !== 12'h000 || busy !== 1'b0 || din !== 8'h21) begin
      n_fail++; $display("FAIL dt1_dropped_write: ups=%h busy=%b din=%h required 000 0 21", ups, busy, din);
    end
  endtask

  task automatic test_keyon_timeout;
    int n;
    reg_write(1'b0, 8'h28, 8'hF5);
    n_checks++;
    if (ups !== 12'h001 || ch !== 3'd5 || op !== 2'd0 || din !== 8'hF5) begin
      n_fail++; $display("FAIL keyon_launch: ups=%h ch=%0d op=%0d din=%h required 001 5 0 f5", ups, ch, op, din);
    end
    n = 0;
    while (up_keyon === 1'b1 && n < 10) begin n++; @(negedge clk); end
    n_checks++;
    if (n != 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL keyon_timeout: strobe cycles=%0d busy=%b required 3 0", n, busy);
    end
  endtask

  task automatic test_ch3_fnum;
    reg_write(1'b0, 8'hAD, 8'h2C);
    n_checks++;
    if (fnum_ch3op1 !== 11'h0 || block_ch3op1 !== 3'd0 || ups !== 12'h000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ch3_hi_only: fnum1=%h block1=%0d ups=%h busy=%b required 0 0 000 0", fnum_ch3op1, block_ch3op1, ups, busy);
    end
    reg_write(1'b0, 8'hA9, 8'h81);
    n_checks++;
    if (fnum_ch3op1 !== 11'h481 || block_ch3op1 !== 3'd5) begin
      n_fail++; $display("FAIL ch3_op1_commit: fnum1=%h block1=%0d required 481 5", fnum_ch3op1, block_ch3op1);
    end
    n_checks++;
    if (fnum_ch3op2 !== 11'h0 || fnum_ch3op3 !== 11'h0 || block_ch3op2 !== 3'd0 || block_ch3op3 !== 3'd0 || ups !== 12'h000) begin
      n_fail++; $display("FAIL ch3_others_unchanged: fnum2=%h fnum3=%h ups=%h required 0 0 000", fnum_ch3op2, fnum_ch3op3, ups);
    end
    reg_write(1'b0, 8'hAE, 8'h0A);
    reg_write(1'b0, 8'hA8, 8'h33);
    n_checks++;
    if (fnum_ch3op3 !== 11'h233 || block_ch3op3 !== 3'd1 || fnum_ch3op1 !== 11'h481) begin
      n_fail++; $display("FAIL ch3_op3_commit: fnum3=%h block3=%0d fnum1=%h required 233 1 481", fnum_ch3op3, block_ch3op3, fnum_ch3op1);
    end
  endtask

  task automatic test_globals;
    reg_write(1'b0, 8'h22, 8'h0D);
    reg_write(1'b0, 8'h24, 8'hAB);
    reg_write(1'b0, 8'h25, 8'h03);
    reg_write(1'b0, 8'h26, 8'h5C);
    n_checks++;
    if (lfo_en !== 1'b1 || lfo_freq !== 3'd5 || value_A !== 10'h2AF || value_B !== 8'h5C) begin
      n_fail++; $display("FAIL timers_lfo: lfo_en=%b freq=%0d A=%h B=%h required 1 5 2af 5c", lfo_en, lfo_freq, value_A, value_B);
    end
    reg_write(1'b0, 8'h27, 8'h95);
    n_checks++;
    if (csm !== 1'b1 || effect !== 1'b0 || load_A !== 1'b1 || load_B !== 1'b0 || en_irq_A !== 1'b1 || en_irq_B !== 1'b0) begin
      n_fail++; $display("FAIL mode_bits: csm=%b eff=%b ldA=%b ldB=%b irqA=%b irqB=%b required 1 0 1 0 1 0", csm, effect, load_A, load_B, en_irq_A, en_irq_B);
    end
    n_checks++;
    if (clr_flag_A !== 1'b1 || clr_flag_B !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL clr_pulse_on: clrA=%b clrB=%b busy=%b required 1 0 0", clr_flag_A, clr_flag_B, busy);
    end
    @(negedge clk);
    n_checks++;
    if (clr_flag_A !== 1'b0 || clr_flag_B !== 1'b0 || csm !== 1'b1) begin
      n_fail++; $display("FAIL clr_pulse_off: clrA=%b clrB=%b csm=%b required 0 0 1", clr_flag_A, clr_flag_B, csm);
    end
  endtask

  task automatic test_ignored;
    reg_write(1'b0, 8'h33, 8'h11);
    n_checks++;
    if (ups !== 12'h000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL ch3_field_ignored: ups=%h busy=%b required 000 0", ups, busy);
    end
    reg_write(1'b1, 8'h27, 8'h4A);
    reg_write(1'b1, 8'hA9, 8'h00);
    n_checks++;
    if (csm !== 1'b1 || effect !== 1'b0 || load_A !== 1'b1 || en_irq_B !== 1'b0 || fnum_ch3op1 !== 11'h481) begin
      n_fail++; $display("FAIL part1_globals_ignored: csm=%b eff=%b ldA=%b irqB=%b fnum1=%h required 1 0 1 0 481", csm, effect, load_A, en_irq_B, fnum_ch3op1);
    end
    reg_write(1'b1, 8'h28, 8'hF0);
    n_checks++;
    if (ups !== 12'h000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL part1_keyon_ignored: ups=%h busy=%b required 000 0", ups, busy);
    end
  endtask

  task automatic test_reset_mid;
    reg_write(1'b0, 8'hB4, 8'hC0);
    n_checks++;
    if (ups !== 12'h800 || ch !== 3'd0 || op !== 2'd1 || din !== 8'hC0) begin
      n_fail++; $display("FAIL pms_launch: ups=%h ch=%0d op=%0d din=%h required 800 0 1 c0", ups, ch, op, din);
    end
    @(negedge clk);
    busy_in = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (dbg_state !== 2'd2 || up_pms !== 1'b1) begin
      n_fail++; $display("FAIL pms_wait_done: state=%0d up_pms=%b required 2 1", dbg_state, up_pms);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ups !== 12'h000 || busy !== 1'b0 || csm !== 1'b0 || fnum_ch3op1 !== 11'h0) begin
      n_fail++; $display("FAIL reset_mid_handshake: ups=%h busy=%b csm=%b fnum1=%h required 000 0 0 0", ups, busy, csm, fnum_ch3op1);
    end
    rst = 1'b0;
    busy_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_tl_handshake;
    test_dt1_drop;
    test_keyon_timeout;
    test_ch3_fnum;
    test_globals;
    test_ignored;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
